// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, data width, the ALU function and its legality check.
// Pure combinational helpers; there is no state in this package.
package alu_pkg;

    localparam int DATA_W = 64;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
        return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) ||
               (ctrl == ALU_SUB) || (ctrl == ALU_PASSB);
    endfunction

    // Illegal codes produce zero so the result never depends on an earlier operation.
    function automatic logic [DATA_W-1:0] alu_exec(input logic [3:0]        ctrl,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] res;
        res = '0;
        case (ctrl)
            ALU_AND:   res = a & b;
            ALU_OR:    res = a | b;
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_PASSB: res = b;
            default:   res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin grant: first requester at or after (last+1) mod NREQ, wrapping.
// Zero latency; gnt is all-zero whenever en is low.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        // Offset NREQ lands back on last itself, so a lone repeat requester is still served.
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One 64-bit ALU shared round-robin between NREQ valid/ready requesters; result registered with winner ID.
// Latency 1 cycle; requests stall (req_ready=0) while the output register is full and not being drained.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                   CLK,
    input  logic                   resetl,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [4*NREQ-1:0]      req_ctrl,
    input  logic [DATA_W*NREQ-1:0] req_a,
    input  logic [DATA_W*NREQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_zero,
    output logic                   rsp_err
);

    rsp_state_t        state_q, state_d;
    logic [IDW-1:0]    last_q, last_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;

    logic              can_accept;
    logic              accept;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_idx;

    logic [3:0]        mux_ctrl;
    logic [DATA_W-1:0] mux_a;
    logic [DATA_W-1:0] mux_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_legal;

    assign can_accept = (state_q == ST_EMPTY) | rsp_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .last    (last_q),
        .en      (can_accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    // One-hot AND-OR select of the winner's operands into the single ALU.
    always_comb begin
        mux_ctrl = '0;
        mux_a    = '0;
        mux_b    = '0;
        for (int i = 0; i < NREQ; i++) begin
            mux_ctrl = mux_ctrl | ({4{gnt[i]}}      & req_ctrl[4*i +: 4]);
            mux_a    = mux_a    | ({DATA_W{gnt[i]}} & req_a[DATA_W*i +: DATA_W]);
            mux_b    = mux_b    | ({DATA_W{gnt[i]}} & req_b[DATA_W*i +: DATA_W]);
        end
    end

    assign alu_legal = alu_ctrl_legal(mux_ctrl);
    assign alu_res   = alu_exec(mux_ctrl, mux_a, mux_b);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (accept)         state_d = ST_FULL;
                else if (rsp_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        last_d     = last_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        if (accept) begin
            last_d     = gnt_idx;
            rsp_id_d   = gnt_idx;
            rsp_data_d = alu_res;
            rsp_zero_d = (alu_res == '0);
            rsp_err_d  = !alu_legal;
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q    <= ST_EMPTY;
            last_q     <= IDW'(NREQ - 1);
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a scoreboard of expected responses.
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] data;
        logic        zero;
        logic        err;
    } exp_t;

    logic                CLK;
    logic                resetl;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_ctrl;
    logic [64*NREQ-1:0]  req_a;
    logic [64*NREQ-1:0]  req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [63:0]         rsp_data;
    logic                rsp_zero;
    logic                rsp_err;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   gnt_log[$];

    logic [63:0] snap_data;
    logic [1:0]  snap_id;
    logic        snap_zero, snap_err, snap_valid;
    int          exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLK       (CLK),
        .resetl    (resetl),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ctrl  (req_ctrl),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int id, input logic [3:0] c,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t m;
        m.id  = 2'(id);
        m.err = 1'b0;
        case (c)
            4'b0000: m.data = a & b;
            4'b0001: m.data = a | b;
            4'b0010: m.data = a + b;
            4'b0110: m.data = a - b;
            4'b0111: m.data = b;
            default: begin m.data = 64'd0; m.err = 1'b1; end
        endcase
        m.zero = (m.data == 64'd0);
        return m;
    endfunction

    task automatic set_req(input int i, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        req_valid[i]       = 1'b1;
        req_ctrl[4*i +: 4] = c;
        req_a[64*i +: 64]  = a;
        req_b[64*i +: 64]  = b;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    // Samples at the falling edge: pops a response on a drain, pushes a model result on an accept.
    task automatic tick();
        exp_t e;
        int   gi;
        @(negedge CLK);
        if (rsp_valid && rsp_ready) begin
            check("sb_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rsp_id",   64'(rsp_id),   64'(e.id));
                check("rsp_data", rsp_data,      e.data);
                check("rsp_zero", 64'(rsp_zero), 64'(e.zero));
                check("rsp_err",  64'(rsp_err),  64'(e.err));
            end
        end
        if (rsp_valid && !rsp_ready)
            check("ready_blocked", 64'(req_ready), 64'd0);
        if (|req_ready) begin
            check("ready_onehot", 64'($countones(req_ready)), 64'd1);
            check("ready_subset", 64'(req_ready & ~req_valid), 64'd0);
            gi = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
            gnt_log.push_back(gi);
            sb.push_back(model(gi, req_ctrl[4*gi +: 4], req_a[64*gi +: 64], req_b[64*gi +: 64]));
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        resetl    = 1'b0;
        req_valid = '0;
        req_ctrl  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        resetl = 1'b1;

        // 1. Reset with a pending result, then first grant goes to req0
        set_req(0, 4'b0010, 64'd3, 64'd4);
        tick();
        clr_req(0);
        check("pend_valid", 64'(rsp_valid), 64'd1);
        #2 resetl = 1'b0;
        #1;
        sb.delete();
        check("arst_valid", 64'(rsp_valid), 64'd0);
        check("arst_data",  rsp_data,       64'd0);
        check("arst_zero",  64'(rsp_zero),  64'd0);
        check("arst_err",   64'(rsp_err),   64'd0);
        check("arst_id",    64'(rsp_id),    64'd0);
        tick();
        resetl = 1'b1;
        check("post_rst_valid", 64'(rsp_valid), 64'd0);
        set_req(0, 4'b0000, 64'hF0F0, 64'hFF00);
        set_req(1, 4'b0001, 64'h1, 64'h2);
        set_req(2, 4'b0010, 64'h5, 64'h6);
        set_req(3, 4'b0111, 64'h9, 64'hA);
        rsp_ready = 1'b1;
        #1;
        check("first_gnt", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;

        // 2. Single ADD wrapping to zero
        set_req(1, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        tick();
        clr_req(1);
        check("t2_valid", 64'(rsp_valid), 64'd1);
        check("t2_id",    64'(rsp_id),    64'd1);
        check("t2_data",  rsp_data,       64'd0);
        check("t2_zero",  64'(rsp_zero),  64'd1);
        check("t2_err",   64'(rsp_err),   64'd0);
        tick();

        // 3. Round-robin over all four; req3 first so the pointer sits at 3
        set_req(3, 4'b0111, 64'd1, 64'h1234);
        tick();
        clr_req(3);
        gnt_log.delete();
        set_req(0, 4'b0110, 64'd0, 64'd1);
        set_req(1, 4'b0000, 64'hDEAD_BEEF_0000_FFFF, 64'hFFFF_0000_FFFF_00FF);
        set_req(2, 4'b0001, 64'h0, 64'h0);
        set_req(3, 4'b0111, 64'h55, 64'hAAAA_5555_0000_1111);
        for (int c = 0; c < 8; c++) begin
            tick();
            if (gnt_log.size() > 0) begin
                int g;
                g = gnt_log[gnt_log.size()-1];
                req_a[64*g +: 64] = {$urandom, $urandom};
                req_b[64*g +: 64] = {$urandom, $urandom};
            end
        end
        req_valid = '0;
        check("rr_count", 64'(gnt_log.size()), 64'd8);
        for (int k = 0; k < 8; k++)
            if (k < gnt_log.size())
                check("rr_order", 64'(gnt_log[k]), 64'(exp_order[k]));
        tick();

        // 4. Backpressure: full register with id1, stall, then drain+accept together
        set_req(1, 4'b0001, 64'hF000, 64'h000F);
        tick();
        clr_req(1);
        rsp_ready = 1'b0;
        set_req(0, 4'b0010, 64'd10, 64'd20);
        set_req(2, 4'b0110, 64'd7, 64'd7);
        snap_valid = rsp_valid;
        snap_id    = rsp_id;
        snap_data  = rsp_data;
        snap_zero  = rsp_zero;
        snap_err   = rsp_err;
        check("bp_full", 64'(snap_valid), 64'd1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_ready", 64'(req_ready), 64'd0);
            tick();
            check("bp_valid", 64'(rsp_valid), 64'(snap_valid));
            check("bp_id",    64'(rsp_id),    64'(snap_id));
            check("bp_data",  rsp_data,       snap_data);
            check("bp_zero",  64'(rsp_zero),  64'(snap_zero));
            check("bp_err",   64'(rsp_err),   64'(snap_err));
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_pulse_gnt", 64'(req_ready), 64'b0100);
        tick();
        clr_req(2);
        check("bp_next_valid", 64'(rsp_valid), 64'd1);
        check("bp_next_id",    64'(rsp_id),    64'd2);
        tick();
        clr_req(0);
        tick();

        // 5. Illegal ctrl still accepted
        set_req(3, 4'b1111, 64'd5, 64'd7);
        #1;
        check("ill_gnt", 64'(req_ready), 64'b1000);
        tick();
        clr_req(3);
        check("ill_id",   64'(rsp_id),   64'd3);
        check("ill_data", rsp_data,      64'd0);
        check("ill_zero", 64'(rsp_zero), 64'd1);
        check("ill_err",  64'(rsp_err),  64'd1);
        tick();

        // 6. Pointer at 2, idle cycles, then wrap past idle req3
        set_req(2, 4'b0111, 64'd0, 64'd9);
        tick();
        clr_req(2);
        repeat (3) tick();
        set_req(0, 4'b0000, 64'hFF, 64'h0F);
        set_req(1, 4'b0010, 64'd100, 64'd23);
        #1;
        check("wrap_gnt0", 64'(req_ready), 64'b0001);
        tick();
        clr_req(0);
        #1;
        check("wrap_gnt1", 64'(req_ready), 64'b0010);
        tick();
        clr_req(1);
        repeat (2) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
